// File: rtl/cpu_controller.sv
// Control unit for the simple CPU: holds the instruction register, decodes it and
// sequences the datapath through a Moore FSM, one instruction per pass.
module cpu_controller #(
    parameter logic [1:0] MEM_NONE  = 2'b00,
    parameter logic [1:0] MEM_READ  = 2'b01,
    parameter logic [1:0] MEM_WRITE = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [1:0]  mem_cmd,
    output logic        addr_sel,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
        S_EXEC, S_WR_REG, S_CALC_ADDR, S_LD_ADDR, S_MEM_RD, S_WB_MEM,
        S_GET_RD, S_PASS_RD, S_MEM_WR, S_HALT
    } state_t;

    state_t      state, next_state;
    logic [15:0] ir;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_movi, is_movr, is_alu, is_ldr, is_str, is_halt;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt = (opcode == 3'b111);

    // Reset wins over everything, so an instruction in flight is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            ir    <= 16'h0000;
        end else begin
            state <= next_state;
            if (state == S_IF2)
                ir <= mem_rdata;
        end
    end

    always_comb begin
        next_state = state;
        vsel       = 4'b1000;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        mem_cmd    = MEM_NONE;
        addr_sel   = 1'b0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        load_addr  = 1'b0;
        halted     = 1'b0;

        case (state)
            S_RST: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                next_state = S_IF1;
            end
            S_IF1: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                next_state = S_IF2;
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                next_state = S_UPD_PC;
            end
            S_UPD_PC: begin
                load_pc    = 1'b1;
                next_state = S_DECODE;
            end
            // Unrecognised encodings fall back to IF1 and behave as a NOP.
            S_DECODE: begin
                if (is_movi)
                    next_state = S_WR_IMM;
                else if (is_movr || (is_alu && op == 2'b11))
                    next_state = S_GET_B;
                else if (is_alu || is_ldr || is_str)
                    next_state = S_GET_A;
                else if (is_halt)
                    next_state = S_HALT;
                else
                    next_state = S_IF1;
            end
            S_WR_IMM: begin
                vsel       = 4'b0010;
                writenum   = rn;
                write      = 1'b1;
                next_state = S_IF1;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = (is_ldr || is_str) ? S_CALC_ADDR : S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end
            // MOV and MVN ignore A, so A is forced to zero; CMP only updates status.
            S_EXEC: begin
                shift      = sh;
                loadc      = 1'b1;
                next_state = S_WR_REG;
                if (is_movr) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    asel  = (op == 2'b11);
                    ALUop = op;
                    if (op == 2'b01) begin
                        loads      = 1'b1;
                        loadc      = 1'b0;
                        next_state = S_IF1;
                    end
                end
            end
            S_WR_REG: begin
                vsel       = 4'b1000;
                writenum   = rd;
                write      = 1'b1;
                next_state = S_IF1;
            end
            S_CALC_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                load_addr  = 1'b1;
                next_state = is_ldr ? S_MEM_RD : S_GET_RD;
            end
            S_MEM_RD: begin
                mem_cmd    = MEM_READ;
                next_state = S_WB_MEM;
            end
            S_WB_MEM: begin
                mem_cmd    = MEM_READ;
                vsel       = 4'b0001;
                writenum   = rd;
                write      = 1'b1;
                next_state = S_IF1;
            end
            S_GET_RD: begin
                readnum    = rd;
                loadb      = 1'b1;
                next_state = S_PASS_RD;
            end
            // Store data must pass through unshifted regardless of the sh field.
            S_PASS_RD: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_cmd    = MEM_WRITE;
                next_state = S_IF1;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_RST;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes the expected control word for
// every cycle, a monitor pops and compares on the falling edge.
module tb_cpu_controller;

    typedef struct packed {
        logic [3:0]  vsel;
        logic        loada, loadb, loadc, loads, asel, bsel;
        logic [1:0]  shift, alu_op;
        logic [2:0]  readnum, writenum;
        logic        write;
        logic [1:0]  mem_cmd;
        logic        addr_sel, load_pc, reset_pc, load_addr, halted;
        logic [15:0] sximm8, sximm5;
    } ctrl_t;

    typedef enum {K_MOVI, K_MOVR, K_ALU, K_MVN, K_CMP, K_LDR, K_STR, K_NOP, K_ABORT, K_HALT} kind_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, asel, bsel, write;
    logic [1:0]  shift, ALUop, mem_cmd;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm8, sximm5;
    logic        addr_sel, load_pc, reset_pc, load_addr, halted;

    int    errors = 0;
    int    checks = 0;
    ctrl_t exp_q[$];
    string tag_q[$];
    ctrl_t act;
    logic [15:0] cur_ir;

    cpu_controller dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .readnum(readnum), .writenum(writenum), .write(write),
        .sximm8(sximm8), .sximm5(sximm5), .mem_cmd(mem_cmd), .addr_sel(addr_sel),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr), .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        act.vsel      = vsel;
        act.loada     = loada;
        act.loadb     = loadb;
        act.loadc     = loadc;
        act.loads     = loads;
        act.asel      = asel;
        act.bsel      = bsel;
        act.shift     = shift;
        act.alu_op    = ALUop;
        act.readnum   = readnum;
        act.writenum  = writenum;
        act.write     = write;
        act.mem_cmd   = mem_cmd;
        act.addr_sel  = addr_sel;
        act.load_pc   = load_pc;
        act.reset_pc  = reset_pc;
        act.load_addr = load_addr;
        act.halted    = halted;
        act.sximm8    = sximm8;
        act.sximm5    = sximm5;
    end

    function automatic ctrl_t base();
        ctrl_t e;
        e        = '0;
        e.vsel   = 4'b1000;
        e.sximm8 = {{8{cur_ir[7]}}, cur_ir[7:0]};
        e.sximm5 = {{11{cur_ir[4]}}, cur_ir[4:0]};
        return e;
    endfunction

    task automatic checkOutput(input ctrl_t e, input string tag);
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", tag, act, e);
        end
    endtask

    // Monitor: the DUT presents a full control word every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0)
                checkOutput(exp_q.pop_front(), tag_q.pop_front());
        end
    end

    task automatic step(input ctrl_t e, input string tag);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic applyStimulus(input logic [15:0] ir, input kind_t kind, input string name);
        ctrl_t e;
        logic [2:0] rn, rd, rm;
        logic [1:0] op, sh;
        rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0]; op = ir[12:11]; sh = ir[4:3];
        mem_rdata = ir;
        e = base(); e.addr_sel = 1'b1; e.mem_cmd = 2'b01;
        step(e, {name, "_if1"});
        step(e, {name, "_if2"});
        cur_ir = ir;
        e = base(); e.load_pc = 1'b1;
        step(e, {name, "_updpc"});
        mem_rdata = 16'hFFFF;
        e = base();
        step(e, {name, "_decode"});
        if (kind inside {K_ALU, K_CMP, K_LDR, K_STR, K_ABORT}) begin
            e = base(); e.readnum = rn; e.loada = 1'b1;
            step(e, {name, "_geta"});
        end
        case (kind)
            K_MOVI: begin
                e = base(); e.vsel = 4'b0010; e.writenum = rn; e.write = 1'b1;
                step(e, {name, "_wrimm"});
            end
            K_MOVR, K_ALU, K_MVN, K_CMP, K_ABORT: begin
                e = base(); e.readnum = rm; e.loadb = 1'b1;
                step(e, {name, "_getb"});
                if (kind == K_ABORT) begin
                    reset = 1'b1;
                    cur_ir = 16'h0000;
                    e = base(); e.reset_pc = 1'b1; e.load_pc = 1'b1;
                    step(e, {name, "_rst"});
                    reset = 1'b0;
                end else begin
                    e = base(); e.shift = sh; e.loadc = 1'b1;
                    e.asel   = (kind == K_MOVR || kind == K_MVN);
                    e.alu_op = (kind == K_MOVR) ? 2'b00 : op;
                    if (kind == K_CMP) begin
                        e.loads = 1'b1; e.loadc = 1'b0;
                    end
                    step(e, {name, "_exec"});
                    if (kind != K_CMP) begin
                        e = base(); e.writenum = rd; e.write = 1'b1;
                        step(e, {name, "_wrreg"});
                    end
                end
            end
            K_LDR, K_STR: begin
                e = base(); e.bsel = 1'b1; e.loadc = 1'b1;
                step(e, {name, "_calc"});
                e = base(); e.load_addr = 1'b1;
                step(e, {name, "_ldaddr"});
                if (kind == K_LDR) begin
                    e = base(); e.mem_cmd = 2'b01;
                    step(e, {name, "_memrd"});
                    e = base(); e.mem_cmd = 2'b01; e.vsel = 4'b0001; e.writenum = rd; e.write = 1'b1;
                    step(e, {name, "_wbmem"});
                end else begin
                    e = base(); e.readnum = rd; e.loadb = 1'b1;
                    step(e, {name, "_getrd"});
                    e = base(); e.asel = 1'b1; e.loadc = 1'b1;
                    step(e, {name, "_passrd"});
                    e = base(); e.mem_cmd = 2'b10;
                    step(e, {name, "_memwr"});
                end
            end
            K_HALT: begin
                e = base(); e.halted = 1'b1;
                for (int i = 0; i < 6; i++)
                    step(e, {name, "_halt"});
            end
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        ctrl_t e;
        reset     = 1'b1;
        mem_rdata = 16'h0000;
        cur_ir    = 16'h0000;
        e = base(); e.reset_pc = 1'b1; e.load_pc = 1'b1;
        step(e, "rst0");
        step(e, "rst1");
        reset = 1'b0;

        applyStimulus(16'hD105, K_MOVI,  "mov_r1_5");
        applyStimulus(16'hD2F0, K_MOVI,  "mov_r2_m16");
        applyStimulus(16'hC06A, K_MOVR,  "mov_r3_r2_lsl");
        applyStimulus(16'hA143, K_ALU,   "add");
        applyStimulus(16'hB143, K_ALU,   "and");
        applyStimulus(16'hB891, K_MVN,   "mvn");
        applyStimulus(16'hA8A1, K_CMP,   "cmp");
        applyStimulus(16'h6043, K_LDR,   "ldr");
        applyStimulus(16'h8043, K_STR,   "str");
        applyStimulus(16'h0000, K_NOP,   "illegal");
        applyStimulus(16'hA143, K_ABORT, "abort");
        applyStimulus(16'hE000, K_HALT,  "halt");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
